// File: rtl/icache_dm.sv
// ============================================================================
//  Module      : icache_dm
//  Description : Direct-mapped, one-word-per-line instruction cache with fill
//                bypass, sequential flush sweep and saturating hit/miss counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_dm #(
    parameter int INDEX_BITS = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic        lookup_i,
    input  logic        we_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        hit_o,
    output logic [31:0] inst_o,
    output logic        busy_o,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
);

    localparam int                    LINES      = 1 << INDEX_BITS;
    localparam int                    TAG_W      = 32 - INDEX_BITS - 2;
    localparam logic [INDEX_BITS-1:0] SWEEP_LAST = {INDEX_BITS{1'b1}};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nx;
    logic [INDEX_BITS-1:0]  r_sweep;
    logic [LINES-1:0]       r_valid;
    logic [TAG_W-1:0]       r_tag  [LINES];
    logic [31:0]            r_data [LINES];
    logic [31:0]            r_hit_cnt;
    logic [31:0]            r_miss_cnt;

    logic [INDEX_BITS-1:0]  w_idx;
    logic [INDEX_BITS-1:0]  w_widx;
    logic [TAG_W-1:0]       w_tag;
    logic [TAG_W-1:0]       w_wtag;
    logic                   w_idle;
    logic                   w_arr_hit;
    logic                   w_bypass;
    logic                   w_fill;
    logic                   w_unused;

    assign w_idx    = addr_i[INDEX_BITS+1:2];
    assign w_tag    = addr_i[31:INDEX_BITS+2];
    assign w_widx   = waddr_i[INDEX_BITS+1:2];
    assign w_wtag   = waddr_i[31:INDEX_BITS+2];
    assign w_unused = ^{addr_i[1:0], waddr_i[1:0]};

    assign w_idle    = (r_state == S_IDLE);
    assign w_arr_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // A fill in flight for the same word wins over whatever the array holds.
    assign w_bypass  = we_i && (waddr_i[31:2] == addr_i[31:2]);
    assign w_fill    = w_idle && we_i && !flush_i;

    assign hit_o      = w_idle && (w_bypass || w_arr_hit);
    assign inst_o     = !hit_o   ? 32'h0 :
                        w_bypass ? wdata_i : r_data[w_idx];
    assign busy_o     = (r_state == S_FLUSH);
    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (flush_i)               w_state_nx = S_FLUSH;
            S_FLUSH: if (r_sweep == SWEEP_LAST) w_state_nx = S_IDLE;
            default:                            w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= '0;
            r_sweep    <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_idle) begin
            if (flush_i) begin
                r_sweep <= '0;
            end else if (we_i) begin
                r_valid[w_widx] <= 1'b1;
            end
            if (lookup_i) begin
                if (hit_o) begin
                    if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
                end else begin
                    if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
                end
            end
        end else begin
            r_valid[r_sweep] <= 1'b0;
            r_sweep          <= r_sweep + 1'b1;
        end
    end

    // Tag and data need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_widx]  <= w_wtag;
            r_data[w_widx] <= wdata_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_icache_dm.sv
// ============================================================================
//  Module      : tb_icache_dm
//  Description : Self-checking bench for icache_dm against a word-address model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_dm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr_i = '0;
    logic        lookup_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] waddr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        flush_i = 1'b0;
    logic        hit_o;
    logic [31:0] inst_o;
    logic        busy_o;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    icache_dm #(.INDEX_BITS(7)) dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .lookup_i(lookup_i),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .flush_i(flush_i),
        .hit_o(hit_o), .inst_o(inst_o), .busy_o(busy_o),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: each line remembers the full word address it holds.
    bit          m_valid [128];
    logic [29:0] m_waddr [128];
    logic [31:0] m_data  [128];
    int          m_flush_left = 0;
    logic [31:0] m_hit_cnt = '0;
    logic [31:0] m_miss_cnt = '0;

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 2) % 128);
    endfunction

    function automatic bit exp_hit();
        if (m_flush_left != 0) return 1'b0;
        if (we_i && waddr_i[31:2] == addr_i[31:2]) return 1'b1;
        return m_valid[line_of(addr_i)] && (m_waddr[line_of(addr_i)] == addr_i[31:2]);
    endfunction

    function automatic logic [31:0] exp_inst();
        if (!exp_hit()) return 32'h0;
        if (we_i && waddr_i[31:2] == addr_i[31:2]) return wdata_i;
        return m_data[line_of(addr_i)];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
            m_flush_left = 0;
            m_hit_cnt    = '0;
            m_miss_cnt   = '0;
        end else if (m_flush_left != 0) begin
            m_valid[128 - m_flush_left] = 1'b0;
            m_flush_left = m_flush_left - 1;
        end else begin
            if (lookup_i) begin
                if (exp_hit()) begin
                    if (m_hit_cnt != 32'hFFFF_FFFF) m_hit_cnt = m_hit_cnt + 1;
                end else if (m_miss_cnt != 32'hFFFF_FFFF) begin
                    m_miss_cnt = m_miss_cnt + 1;
                end
            end
            if (flush_i) begin
                m_flush_left = 128;
            end else if (we_i) begin
                m_valid[line_of(waddr_i)] = 1'b1;
                m_waddr[line_of(waddr_i)] = waddr_i[31:2];
                m_data[line_of(waddr_i)]  = wdata_i;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("model_hit",  {31'd0, hit_o},  {31'd0, exp_hit()});
        chk("model_inst", inst_o,          exp_inst());
        chk("model_busy", {31'd0, busy_o}, {31'd0, m_flush_left != 0});
        chk("model_hcnt", hit_cnt_o,       m_hit_cnt);
        chk("model_mcnt", miss_cnt_o,      m_miss_cnt);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lk, input logic [31:0] a, input logic we,
                         input logic [31:0] wa, input logic [31:0] wd, input logic fl);
        lookup_i = lk; addr_i = a; we_i = we; waddr_i = wa; wdata_i = wd; flush_i = fl;
    endtask

    int busy_cycles;

    initial begin
        #2;
        chk("rst_hit",  {31'd0, hit_o},  32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_hcnt", hit_cnt_o,       32'd0);
        #20 rst = 1'b0;
        cyc();

        // Cold lookup misses
        drive(1, 32'h0000_1000, 0, 0, 0, 0);
        #2 chk("cold_hit", {31'd0, hit_o}, 32'd0);
        chk("cold_inst", inst_o, 32'd0);
        cyc();
        drive(0, 32'h0000_1000, 0, 0, 0, 0);
        #2 chk("cold_mcnt", miss_cnt_o, 32'd1);

        // Bypass then array hit
        cyc();
        drive(1, 32'h0000_1000, 1, 32'h0000_1000, 32'h0000_0513, 0);
        #2 chk("byp_hit", {31'd0, hit_o}, 32'd1);
        chk("byp_inst", inst_o, 32'h0000_0513);
        cyc();
        drive(1, 32'h0000_1000, 0, 0, 0, 0);
        #2 chk("arr_inst", inst_o, 32'h0000_0513);
        cyc();
        drive(0, 32'h0000_1000, 0, 0, 0, 0);
        #2 chk("arr_hcnt", hit_cnt_o, 32'd2);

        // Same index, different tag replaces the line
        cyc();
        drive(0, 0, 1, 32'h0000_1200, 32'hAAAA_AAAA, 0);
        cyc();
        drive(1, 32'h0000_1000, 0, 0, 0, 0);
        #2 chk("repl_old", {31'd0, hit_o}, 32'd0);
        cyc();
        drive(1, 32'h0000_1200, 0, 0, 0, 0);
        #2 chk("repl_new", inst_o, 32'hAAAA_AAAA);

        // Fill three lines then flush with a simultaneous fill
        cyc(); drive(0, 0, 1, 32'h0000_2004, 32'h1111_1111, 0);
        cyc(); drive(0, 0, 1, 32'h0000_2008, 32'h2222_2222, 0);
        cyc(); drive(0, 0, 1, 32'h0000_200C, 32'h3333_3333, 0);
        cyc(); drive(1, 32'h0000_2008, 0, 0, 0, 0);
        #2 chk("pre_flush", inst_o, 32'h2222_2222);
        cyc(); drive(0, 32'h0000_2004, 1, 32'h0000_3010, 32'h4444_4444, 1);
        cyc(); drive(1, 32'h0000_2004, 1, 32'h0000_2004, 32'h5555_5555, 0);
        busy_cycles = 0;
        for (int i = 0; i < 300 && busy_o; i++) begin
            if (i == 10) flush_i = 1'b1;
            else flush_i = 1'b0;
            busy_cycles++;
            cyc();
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("flush_len", busy_cycles, 32'd128);
        drive(1, 32'h0000_2004, 0, 0, 0, 0); #2 chk("fl_miss0", {31'd0, hit_o}, 32'd0);
        cyc(); drive(1, 32'h0000_2008, 0, 0, 0, 0); #2 chk("fl_miss1", {31'd0, hit_o}, 32'd0);
        cyc(); drive(1, 32'h0000_200C, 0, 0, 0, 0); #2 chk("fl_miss2", {31'd0, hit_o}, 32'd0);
        cyc(); drive(1, 32'h0000_3010, 0, 0, 0, 0); #2 chk("fl_drop",  {31'd0, hit_o}, 32'd0);

        // Hit counter saturation
        cyc(); drive(0, 0, 0, 0, 0, 0);
        force dut.r_hit_cnt = 32'hFFFF_FFFE;
        m_hit_cnt = 32'hFFFF_FFFE;
        cyc();
        release dut.r_hit_cnt;
        drive(1, 32'h0000_4000, 1, 32'h0000_4000, 32'h6666_6666, 0);
        cyc();
        cyc(); drive(0, 0, 0, 0, 0, 0);
        #2 chk("sat_hcnt", hit_cnt_o, 32'hFFFF_FFFF);

        // Reset in the middle of a sweep
        cyc(); drive(0, 0, 0, 0, 0, 1);
        cyc(); drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) cyc();
        chk("mid_busy", {31'd0, busy_o}, 32'd1);
        rst = 1'b1;
        #1 chk("rst_busy2", {31'd0, busy_o}, 32'd0);
        chk("rst_hcnt2", hit_cnt_o, 32'd0);
        chk("rst_mcnt2", miss_cnt_o, 32'd0);
        cyc(); rst = 1'b0;
        drive(1, 32'h0000_4000, 0, 0, 0, 0); #2 chk("post_rst0", {31'd0, hit_o}, 32'd0);
        cyc(); drive(1, 32'h0000_1200, 0, 0, 0, 0); #2 chk("post_rst1", {31'd0, hit_o}, 32'd0);
        cyc(); drive(0, 0, 0, 0, 0, 0);
        #2 chk("post_mcnt", miss_cnt_o, 32'd2);
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 Parameter INDEX_BITS, default 7, log2 of the line count (128 one-word lines).
REQ-002 Port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port addr_i  input  32  fetch address (PC) to look up; bits [1:0] ignored.
REQ-005 Port lookup_i  input  1  marks addr_i as a real fetch lookup this cycle; gates the statistics counters only.
REQ-006 Port we_i  input  1  fill request from the memory controller (line write).
REQ-007 Port waddr_i  input  32  fill address; bits [1:0] ignored.
REQ-008 Port wdata_i  input  32  fill instruction word.
REQ-009 Port flush_i  input  1  single-cycle pulse; requests invalidation of all lines.
REQ-010 Port hit_o  output  1  addr_i hits this cycle (combinational).
REQ-011 Port inst_o  output  32  instruction for addr_i when hit_o=1, else 32'h0.
REQ-012 Port busy_o  output  1  flush sweep in progress.
REQ-013 Port hit_cnt_o  output  32  saturating count of lookup hits.
REQ-014 Port miss_cnt_o  output  32  saturating count of lookup misses.

Function
REQ-015 Address split: index = addr[INDEX_BITS+1:2]; tag = addr[31:INDEX_BITS+2] (23 bits at default); same split applies to waddr_i.
REQ-016 Storage per line: valid bit, tag, 32-bit data; data and tag arrays need no reset, valid bits do.
REQ-017 FSM states: IDLE, FLUSH; busy_o=1 exactly when state=FLUSH.
REQ-018 IDLE lookup: hit_o=1 when valid[index] and stored tag equals addr_i tag; inst_o = stored data.
REQ-019 Write bypass: in IDLE with we_i=1 and waddr_i[31:2]=addr_i[31:2], hit_o=1 and inst_o=wdata_i in the same cycle, overriding stored contents.
REQ-020 Fill: rising edge with state=IDLE, we_i=1, flush_i=0 writes data, tag and sets valid at waddr_i index; visible via the array from the next cycle.
REQ-021 Fill to an occupied index overwrites the line regardless of its tag (direct-mapped replacement).
REQ-022 IDLE, flush_i=1: next state FLUSH, sweep counter loaded with 0; any simultaneous we_i is dropped.
REQ-023 FLUSH: each cycle clears valid[sweep counter] and increments the counter; when the counter equals 2^INDEX_BITS-1, that line is cleared and the next state is IDLE; sweep lasts exactly 2^INDEX_BITS cycles.
REQ-024 During FLUSH: hit_o=0, inst_o=0, we_i ignored (fill lost), flush_i ignored (no restart), counters frozen.
REQ-025 Counters: at a rising edge in IDLE with lookup_i=1, increment hit_cnt_o if hit_o=1 else miss_cnt_o; bypass hits count as hits.
REQ-026 Counters saturate at 32'hFFFFFFFF, never wrap.
REQ-027 Sweep counter is INDEX_BITS wide; wraps to 0 on leaving FLUSH.

Reset
REQ-028 rst=1 immediately: state IDLE, all valid bits 0, sweep counter 0, hit_cnt_o=0, miss_cnt_o=0, busy_o=0, hence hit_o=0, inst_o=0.
REQ-029 Reset asserted mid-FLUSH or during a fill aborts it; no partial valid state survives.

Verification
REQ-030 After reset, lookup_i=1, addr_i=0x0000_1000 one cycle -> hit_o=0, inst_o=0, miss_cnt_o=1 next cycle.
REQ-031 Fill waddr=0x0000_1000, wdata=0x0000_0513 with addr_i=0x0000_1000 -> hit_o=1, inst_o=0x0000_0513 same cycle (bypass); next cycle, we_i=0 -> still hit via array.
REQ-032 Fill 0x0000_1000 then 0x0000_1200 (same index, different tag), wdata 0xAAAA_AAAA -> lookup 0x0000_1000 misses, 0x0000_1200 hits with 0xAAAA_AAAA.
REQ-033 Fill 3 lines, pulse flush_i with we_i=1 -> busy_o=1 for exactly 128 cycles, fill dropped, hit_o=0 throughout; after busy_o falls all 3 addresses miss.
REQ-034 Force hit_cnt_o to 0xFFFF_FFFE (or run long), two hit lookups -> hit_cnt_o holds 0xFFFF_FFFF.
REQ-035 Assert rst at sweep cycle 40 -> busy_o=0 immediately, counters 0, all lookups miss after release.
